// File: rtl/imem_if.sv
// Instruction-memory request/response channel: one outstanding request,
// accepted on gnt, answered later by rvalid/rdata.
interface imem_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches one instruction at a time and
// buffers it for the IF/ID register, honouring freeze and branch redirects.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         freeze,
  input  logic         branch_taken,
  input  logic [31:0]  branch_addr,
  imem_if.master       imem,
  output logic [31:0]  PC,
  output logic [31:0]  Instruction,
  output logic         if_valid
);

  typedef enum logic [1:0] {REQ, WAIT, DRAIN, FULL} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] buf_pc;
  logic [31:0] buf_instr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= REQ;
      fetch_pc  <= RESET_PC;
      buf_pc    <= '0;
      buf_instr <= '0;
    end else begin
      case (state)
        REQ: begin
          if (branch_taken) begin
            // A request granted this cycle went out with the old address,
            // so its response must be drained before refetching.
            fetch_pc <= branch_addr;
            state    <= imem.gnt ? DRAIN : REQ;
          end else if (imem.gnt) begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (branch_taken) begin
            fetch_pc <= branch_addr;
            state    <= imem.rvalid ? REQ : DRAIN;
          end else if (imem.rvalid) begin
            buf_instr <= imem.rdata;
            buf_pc    <= fetch_pc;
            state     <= FULL;
          end
        end

        DRAIN: begin
          if (branch_taken) fetch_pc <= branch_addr;
          if (imem.rvalid)  state    <= REQ;
        end

        FULL: begin
          if (branch_taken) begin
            fetch_pc  <= branch_addr;
            buf_pc    <= '0;
            buf_instr <= '0;
            state     <= REQ;
          end else if (!freeze) begin
            fetch_pc  <= buf_pc + PC_STEP;
            buf_pc    <= '0;
            buf_instr <= '0;
            state     <= REQ;
          end
        end

        default: state <= REQ;
      endcase
    end
  end

  // NOTE: every output gets a value on every path, so no latches are inferred.
  always_comb begin
    imem.req    = (state == REQ);
    imem.addr   = fetch_pc;
    if_valid    = (state == FULL);
    PC          = (state == FULL) ? buf_pc + PC_STEP : 32'h0;
    Instruction = (state == FULL) ? buf_instr : 32'h0;
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage with a small instruction
// memory model whose response latency and grant can be controlled.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        if_valid;

  logic        gnt_en;
  int unsigned mem_lat;
  logic        pend;
  int unsigned cnt;
  logic [31:0] paddr;

  int checks = 0;
  int errors = 0;

  imem_if imem ();

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem         (imem),
    .PC           (PC),
    .Instruction  (Instruction),
    .if_valid     (if_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Memory model: grant when enabled, answer mem_lat cycles after the grant.
  assign imem.gnt    = imem.req & gnt_en;
  assign imem.rvalid = pend && (cnt == 1);
  assign imem.rdata  = mem_word(paddr);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
      cnt  <= 0;
    end else if (imem.req && imem.gnt) begin
      pend  <= 1'b1;
      paddr <= imem.addr;
      cnt   <= mem_lat;
    end else if (pend) begin
      if (cnt == 1) pend <= 1'b0;
      else          cnt  <= cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Entered at a negedge in REQ; leaves at the negedge of the following REQ.
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] exp_instr,
                           input logic [31:0] exp_pc);
    check("req", {31'b0, imem.req}, 32'd1);
    check("addr", imem.addr, addr);
    step();
    check("wait_valid", {31'b0, if_valid}, 32'd0);
    step();
    check("full_valid", {31'b0, if_valid}, 32'd1);
    check("instr", Instruction, exp_instr);
    check("pc", PC, exp_pc);
    check("full_req", {31'b0, imem.req}, 32'd0);
    step();
    check("after_valid", {31'b0, if_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    gnt_en = 1'b1; mem_lat = 1;
    step(); step();
    check("rst_pc", PC, 32'h0);
    check("rst_instr", Instruction, 32'h0);
    check("rst_valid", {31'b0, if_valid}, 32'd0);
    check("rst_req", {31'b0, imem.req}, 32'd1);
    check("rst_addr", imem.addr, 32'h0);
    rst = 1'b0;

    // Sequential fetches, one instruction every third cycle.
    fetch_one(32'h0,  32'hDEAD_0000, 32'h4);
    fetch_one(32'h4,  32'hDEAD_0004, 32'h8);
    fetch_one(32'h8,  32'hDEAD_0008, 32'hC);
    fetch_one(32'hC,  32'hDEAD_000C, 32'h10);

    // Freeze for three cycles while holding the instruction at 0x10.
    check("f_addr", imem.addr, 32'h10);
    step(); step();
    check("f_instr0", Instruction, 32'hDEAD_0010);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("frz_valid", {31'b0, if_valid}, 32'd1);
      check("frz_instr", Instruction, 32'hDEAD_0010);
      check("frz_pc", PC, 32'h14);
      check("frz_req", {31'b0, imem.req}, 32'd0);
    end
    freeze = 1'b0;
    step();
    check("unfrz_req", {31'b0, imem.req}, 32'd1);
    check("unfrz_addr", imem.addr, 32'h14);

    fetch_one(32'h14, 32'hDEAD_0014, 32'h18);
    fetch_one(32'h18, 32'hDEAD_0018, 32'h1C);
    fetch_one(32'h1C, 32'hDEAD_001C, 32'h20);

    // Branch to 0x100 while waiting (rvalid low) on the 0x20 fetch.
    mem_lat = 2;
    check("b1_addr", imem.addr, 32'h20);
    step();
    branch_taken = 1'b1; branch_addr = 32'h100;
    step();
    branch_taken = 1'b0;
    check("drain_valid", {31'b0, if_valid}, 32'd0);
    check("drain_req", {31'b0, imem.req}, 32'd0);
    check("drain_rvalid", {31'b0, imem.rvalid}, 32'd1);
    step();
    check("b1_valid", {31'b0, if_valid}, 32'd0);
    mem_lat = 1;
    fetch_one(32'h100, 32'hDEAD_0100, 32'h104);

    // Branch to 0x40 in the same cycle rvalid arrives.
    step();
    check("b2_rvalid", {31'b0, imem.rvalid}, 32'd1);
    branch_taken = 1'b1; branch_addr = 32'h40;
    step();
    branch_taken = 1'b0;
    check("b2_valid", {31'b0, if_valid}, 32'd0);
    fetch_one(32'h40, 32'hDEAD_0040, 32'h44);

    // Branch wins over freeze while FULL.
    step(); step();
    check("b3_full", {31'b0, if_valid}, 32'd1);
    freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h80;
    step();
    freeze = 1'b0; branch_taken = 1'b0;
    check("b3_valid", {31'b0, if_valid}, 32'd0);
    check("b3_instr", Instruction, 32'h0);
    check("b3_pc", PC, 32'h0);
    fetch_one(32'h80, 32'hDEAD_0080, 32'h84);

    // Ungranted branch to the top of the address space, then wrap to 0.
    gnt_en = 1'b0;
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    gnt_en = 1'b1;
    fetch_one(32'hFFFF_FFFC, 32'h2152_FFFC, 32'h0);
    check("wrap_addr", imem.addr, 32'h0);
    fetch_one(32'h0, 32'hDEAD_0000, 32'h4);

    // Grant held off for four cycles, then reset in the middle of WAIT.
    gnt_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("ng_req", {31'b0, imem.req}, 32'd1);
      check("ng_addr", imem.addr, 32'h4);
    end
    gnt_en = 1'b1; mem_lat = 3;
    step();
    check("w_req", {31'b0, imem.req}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0; mem_lat = 1;
    check("r2_addr", imem.addr, 32'h0);
    check("r2_valid", {31'b0, if_valid}, 32'd0);
    check("r2_instr", Instruction, 32'h0);
    check("r2_req", {31'b0, imem.req}, 32'd1);
    fetch_one(32'h0, 32'hDEAD_0000, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
